// File: rtl/fm_wm_pkg.sv
// fm_wm_pkg: shared FSM state encoding and default base address for the
// feature-map x weight-matrix result writer.
package fm_wm_pkg;

  // Result writer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Address of result element (0,0) in the output memory
  localparam logic [12:0] DEFAULT_BASE_ADDRESS = 13'h400;

endpackage

// File: rtl/fm_wm_result_sat.sv
// fm_wm_result_sat: combinational accumulator -> output element converter.
// Build option FM_WM_RESULT_SATURATE_EN: when defined, values outside the
// signed OUT_WIDTH range clamp to the most positive / most negative code;
// when undefined, the low OUT_WIDTH bits are passed through unchanged.
module fm_wm_result_sat #(
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  output logic [OUT_WIDTH-1:0] data_o
);

`ifdef FM_WM_RESULT_SATURATE_EN
  // The value fits when the sign bit of the output and every discarded
  // upper bit all agree; any disagreement means overflow.
  logic [ACC_WIDTH-OUT_WIDTH:0] top_bits;
  assign top_bits = acc_i[ACC_WIDTH-1:OUT_WIDTH-1];

  // Clamp on overflow, direction taken from the accumulator sign
  always_comb begin
    data_o = acc_i[OUT_WIDTH-1:0];
    if ((|top_bits) && !(&top_bits)) begin
      data_o = acc_i[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  // Plain truncation; upper accumulator bits are intentionally dropped
  logic unused_hi;
  assign unused_hi = ^acc_i[ACC_WIDTH-1:OUT_WIDTH];
  assign data_o    = acc_i[OUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/fm_wm_result_writer.sv
// fm_wm_result_writer: accepts FEATURE_ROWS x WEIGHT_COLS product elements in
// row-major order and writes each to BASE_ADDRESS + row*WEIGHT_COLS + col with
// one cycle of write latency, then pulses done_o. Element conversion is done
// by fm_wm_result_sat (saturation selected by FM_WM_RESULT_SATURATE_EN).
module fm_wm_result_writer
  import fm_wm_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 13,
  parameter int                       FEATURE_ROWS  = 6,
  parameter int                       WEIGHT_COLS   = 3,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = ADDRESS_WIDTH'(DEFAULT_BASE_ADDRESS),
  parameter int                       ACC_WIDTH     = 24,
  parameter int                       OUT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     in_valid_i,
  input  logic [ACC_WIDTH-1:0]     in_data_i,
  output logic                     in_ready_o,
  output logic                     mem_wr_en_o,
  output logic [ADDRESS_WIDTH-1:0] mem_wr_address_o,
  output logic [OUT_WIDTH-1:0]     mem_wr_data_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int ROW_W = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam int COL_W = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WEIGHT_COLS - 1);

  state_t                   state_q;
  logic [ROW_W-1:0]         row_q;
  logic [COL_W-1:0]         col_q;
  logic                     mem_wr_en_q;
  logic [ADDRESS_WIDTH-1:0] mem_wr_address_q;
  logic [OUT_WIDTH-1:0]     mem_wr_data_q;
  logic                     done_q;

  logic                     handshake;
  logic                     last_col;
  logic                     last_elem;
  logic [ADDRESS_WIDTH-1:0] elem_address_d;
  logic [OUT_WIDTH-1:0]     elem_data_d;

  // Element conversion (truncate or saturate)
  fm_wm_result_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat (
    .acc_i  (in_data_i),
    .data_o (elem_data_d)
  );

  assign handshake = in_valid_i && (state_q == WRITE);
  assign last_col  = (col_q == LAST_COL);
  assign last_elem = last_col && (row_q == LAST_ROW);

  // Row-major address; arithmetic wraps at ADDRESS_WIDTH bits by construction
  assign elem_address_d = BASE_ADDRESS
                        + ADDRESS_WIDTH'(row_q) * ADDRESS_WIDTH'(WEIGHT_COLS)
                        + ADDRESS_WIDTH'(col_q);

  // FSM, element counters and registered memory-write outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      row_q            <= '0;
      col_q            <= '0;
      mem_wr_en_q      <= 1'b0;
      mem_wr_address_q <= '0;
      mem_wr_data_q    <= '0;
      done_q           <= 1'b0;
    end else begin
      mem_wr_en_q <= handshake;
      done_q      <= 1'b0;
      if (handshake) begin
        mem_wr_address_q <= elem_address_d;
        mem_wr_data_q    <= elem_data_d;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= WRITE;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        WRITE: begin
          if (handshake) begin
            if (last_elem) begin
              // Final element: the DONE cycle lines up with its write strobe
              state_q <= DONE;
              done_q  <= 1'b1;
              row_q   <= '0;
              col_q   <= '0;
            end else if (last_col) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o       = (state_q == WRITE);
  assign busy_o           = (state_q == WRITE);
  assign mem_wr_en_o      = mem_wr_en_q;
  assign mem_wr_address_o = mem_wr_address_q;
  assign mem_wr_data_o    = mem_wr_data_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_fm_wm_result_writer.sv
// tb_fm_wm_result_writer: randomized self-checking bench with a behavioural
// model that tracks the element index k (address = BASE + k) per matrix.
module tb_fm_wm_result_writer;

  localparam int          ROWS  = 6;
  localparam int          COLS  = 3;
  localparam int          NELEM = ROWS * COLS;
  localparam logic [12:0] BASE  = 13'h400;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        in_valid_i;
  logic [23:0] in_data_i;
  logic        in_ready_o;
  logic        mem_wr_en_o;
  logic [12:0] mem_wr_address_o;
  logic [15:0] mem_wr_data_o;
  logic        busy_o;
  logic        done_o;

  fm_wm_result_writer dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .start_i          (start_i),
    .in_valid_i       (in_valid_i),
    .in_data_i        (in_data_i),
    .in_ready_o       (in_ready_o),
    .mem_wr_en_o      (mem_wr_en_o),
    .mem_wr_address_o (mem_wr_address_o),
    .mem_wr_data_o    (mem_wr_data_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  // Model: phase 0 = waiting for start, 1 = accepting, 2 = completion cycle
  int          m_phase;
  int          m_k;
  logic        exp_en;
  logic [12:0] exp_addr;
  logic [15:0] exp_data;

  logic [33:0] obs;
  assign obs = {mem_wr_en_o, mem_wr_address_o, mem_wr_data_o, done_o, busy_o, in_ready_o};

  function automatic logic [15:0] conv(input logic [23:0] x);
    int s;
    s = int'($signed(x));
`ifdef FM_WM_RESULT_SATURATE_EN
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return x[15:0];
  endfunction

  function automatic logic [33:0] exp_vec();
    return {exp_en, exp_addr, exp_data, (m_phase == 2), (m_phase == 1), (m_phase == 1)};
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_k      = 0;
    exp_en   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  // Drive one cycle of inputs, advance one clock, update the model
  task automatic tick(input logic s, input logic v, input logic [23:0] d);
    logic hs;
    start_i    = s;
    in_valid_i = v;
    in_data_i  = d;
    @(posedge clk_i);
    hs     = (m_phase == 1) && v;
    exp_en = hs;
    if (hs) begin
      exp_addr = BASE + 13'(m_k);
      exp_data = conv(d);
    end
    case (m_phase)
      0: if (s) begin m_phase = 1; m_k = 0; end
      1: if (hs) begin
           if (m_k == NELEM - 1) m_phase = 2;
           m_k++;
         end
      default: m_phase = 0;
    endcase
    #1;
    if (exp_en) $display("write k=%0d addr=%h data=%h", m_k - 1, exp_addr, exp_data);
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
    model_reset();
    #3;
    vectors++;
    if (obs !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_async got=%h exp=%h", obs, 34'd0);
    end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_release got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    tick(1'b1, 1'b0, 24'd0);
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL b2b_start got=%h exp=%h", obs, exp_vec());
    end
    for (int i = 1; i <= NELEM; i++) begin
      tick(1'b0, 1'b1, 24'(i));
      dones += int'(done_o);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b_elem i=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    vectors++;
    if ({done_o, mem_wr_en_o, mem_wr_address_o, mem_wr_data_o} !== {1'b1, 1'b1, 13'h411, 16'd18}) begin
      miscompares++;
      $display("FAIL b2b_last got done=%b en=%b a=%h d=%h exp done=1 en=1 a=0411 d=0012",
               done_o, mem_wr_en_o, mem_wr_address_o, mem_wr_data_o);
    end
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL b2b_done_count got=%0d exp=1", dones);
    end
    tick(1'b0, 1'b0, 24'd0);
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL b2b_idle got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_toggle_valid();
    int writes = 0;
    int cyc    = 0;
    tick(1'b1, 1'b0, 24'd0);
    while (m_phase != 0 && cyc < 100) begin
      tick(1'b0, (cyc % 2) == 0, 24'($urandom));
      writes += int'(mem_wr_en_o);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL toggle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      cyc++;
    end
    vectors++;
    if (writes != NELEM || cyc >= 100) begin
      miscompares++;
      $display("FAIL toggle_writes got=%0d exp=%0d cycles=%0d", writes, NELEM, cyc);
    end
    tick(1'b0, 1'b0, 24'd0);
  endtask

  task automatic test_conversion();
    logic [15:0] e1;
    logic [15:0] e2;
`ifdef FM_WM_RESULT_SATURATE_EN
    e1 = 16'h7FFF; e2 = 16'h8000;
`else
    e1 = 16'h2345; e2 = 16'h0000;
`endif
    tick(1'b1, 1'b0, 24'd0);
    tick(1'b0, 1'b1, 24'h012345);
    vectors++;
    if (mem_wr_data_o !== e1) begin
      miscompares++;
      $display("FAIL conv_pos got=%h exp=%h", mem_wr_data_o, e1);
    end
    tick(1'b0, 1'b1, 24'hFF0000);
    vectors++;
    if (mem_wr_data_o !== e2) begin
      miscompares++;
      $display("FAIL conv_neg got=%h exp=%h", mem_wr_data_o, e2);
    end
    for (int i = 2; i < NELEM + 1; i++) begin
      tick(1'b0, 1'b1, 24'($urandom));
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL conv_rand i=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    tick(1'b0, 1'b0, 24'd0);
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 24'($urandom));
      vectors++;
      if (obs !== exp_vec() || in_ready_o !== 1'b0 || mem_wr_en_o !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_ignore i=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      int cyc = 0;
      tick(1'b1, 1'b0, 24'd0);
      while (m_phase != 0 && cyc < 400) begin
        tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 99) < 60), 24'($urandom));
        vectors++;
        if (obs !== exp_vec()) begin
          miscompares++;
          $display("FAIL random m=%0d cyc=%0d got=%h exp=%h", n, cyc, obs, exp_vec());
        end
        cyc++;
      end
      vectors++;
      if (cyc >= 400) begin
        miscompares++;
        $display("FAIL random_timeout m=%0d got=%0d exp<400", n, cyc);
      end
      tick(1'b0, 1'b0, 24'd0);
    end
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    tick(1'b1, 1'b0, 24'd0);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 24'($urandom));
    reset_i = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (obs !== 34'd0) begin
      miscompares++;
      $display("FAIL midreset_async got=%h exp=%h", obs, 34'd0);
    end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 24'($urandom));
      dones += int'(done_o);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL midreset_after i=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL midreset_done got=%0d exp=0", dones);
    end
    tick(1'b1, 1'b0, 24'd0);
    tick(1'b0, 1'b1, 24'd5);
    vectors++;
    if ({mem_wr_en_o, mem_wr_address_o} !== {1'b1, 13'h400} || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL midreset_restart got en=%b a=%h exp en=1 a=0400", mem_wr_en_o, mem_wr_address_o);
    end
    for (int i = 1; i < NELEM; i++) tick(1'b0, 1'b1, 24'($urandom));
    tick(1'b0, 1'b0, 24'd0);
  endtask

  task automatic test_start_held();
    int dones  = 0;
    int firsts = 0;
    for (int i = 0; i < 45; i++) begin
      tick(1'b1, 1'b1, 24'($urandom));
      dones  += int'(done_o);
      firsts += int'(mem_wr_en_o && mem_wr_address_o == BASE);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL start_held cyc=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    vectors++;
    if (dones != 2 || firsts != 3) begin
      miscompares++;
      $display("FAIL start_held_counts got dones=%0d firsts=%0d exp dones=2 firsts=3", dones, firsts);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_toggle_valid();
    test_conversion();
    test_idle_ignore();
    test_random();
    test_mid_reset();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
